// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared opcodes, classes, states and next-PC encodings
package datapath_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0111;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_JUMP  = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1110;
    localparam logic [3:0] OP_BNE   = 4'b1111;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_JUMP,
        CLS_BEQ,
        CLS_BNE
    } op_class_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERR
    } state_t;

endpackage

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - combinational opcode to instruction-class decode
module opcode_classifier
    import datapath_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class
);

    // Everything not explicitly listed is an ALU operation.
    always_comb begin
        op_class = CLS_ALU;
        case (opcode)
            OP_LOAD:  op_class = CLS_LOAD;
            OP_STORE: op_class = CLS_STORE;
            OP_JUMP:  op_class = CLS_JUMP;
            OP_BEQ:   op_class = CLS_BEQ;
            OP_BNE:   op_class = CLS_BNE;
            default:  op_class = CLS_ALU;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - multi-cycle control FSM with memory wait timeout and retire counter
module datapath_sequencer
    import datapath_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [3:0]       opcode,
    input  logic             eq,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             rf_read,
    output logic             alu_en,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             wb_sel,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    localparam int              WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_t            state;
    op_class_t         cls;
    op_class_t         dec_cls;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  retire_cnt;
    state_t            boundary_next;

    opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (dec_cls)
    );

    // A halt request is honoured only where the next fetch would begin.
    assign boundary_next = stop ? S_IDLE : S_FETCH;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cls      <= CLS_ALU;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_FETCH;
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    cls   <= dec_cls;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (cls)
                        CLS_ALU: state <= S_WB;
                        CLS_LOAD, CLS_STORE: begin
                            wait_cnt <= '0;
                            state    <= S_MEM;
                        end
                        default: state <= boundary_next;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= (cls == CLS_LOAD) ? S_WB : boundary_next;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST)
                            state <= S_ERR;
                    end
                end
                S_WB:    state <= boundary_next;
                S_ERR:   state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ir_load   = 1'b0;
        rf_read   = 1'b0;
        alu_en    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = PC_INC;
        busy      = (state != S_IDLE) && (state != S_ERR);
        error     = (state == S_ERR);
        case (state)
            S_FETCH:  ir_load = 1'b1;
            S_DECODE: rf_read = 1'b1;
            S_EXEC: begin
                alu_en = 1'b1;
                case (cls)
                    CLS_JUMP: begin
                        pc_en  = 1'b1;
                        pc_sel = PC_JUMP;
                    end
                    CLS_BEQ: begin
                        pc_en  = 1'b1;
                        pc_sel = eq ? PC_BRANCH : PC_INC;
                    end
                    CLS_BNE: begin
                        pc_en  = 1'b1;
                        pc_sel = eq ? PC_INC : PC_BRANCH;
                    end
                    default: pc_en = 1'b0;
                endcase
            end
            S_MEM: begin
                mem_read  = (cls == CLS_LOAD);
                mem_write = (cls == CLS_STORE);
                // A store retires in the same cycle memory acknowledges it.
                pc_en     = (cls == CLS_STORE) && mem_ready;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_en     = 1'b1;
                wb_sel    = (cls == CLS_LOAD);
            end
            default: busy = busy;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retire_cnt <= '0;
        else if (pc_en)
            retire_cnt <= retire_cnt + 1'b1;
    end

    assign instr_count = retire_cnt;

endmodule
